// File: rtl/fir3_seq_ctrl.sv
// fir3_seq_ctrl: sequencer for the 3-way parallel direct-form FIR datapath.
// Loads exactly 3*(N/3) coefficients per configuration, then feeds sample
// triplets, and produces a y_valid strobe aligned with the datapath outputs.
// Optional feature macro: FIR3_CTRL_WARMUP_EN. When defined, y_valid is held
// low after each load until M starts have refilled the delay line.
module fir3_seq_ctrl #(
  parameter int N = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic        coeff_valid,
  input  logic [15:0] coeff_data,
  output logic        coeff_ready,
  input  logic        smp_valid,
  input  logic [15:0] smp_x0,
  input  logic [15:0] smp_x1,
  input  logic [15:0] smp_x2,
  output logic        smp_ready,
  output logic [15:0] fir_coeff_in,
  output logic        fir_load_coeff,
  output logic [15:0] fir_x0,
  output logic [15:0] fir_x1,
  output logic [15:0] fir_x2,
  output logic        fir_start,
  output logic        y_valid,
  output logic        coeff_loaded,
  output logic        busy
);

  localparam int M      = N / 3;
  localparam int NC     = 3 * M;
  localparam int CIDX_W = $clog2(NC);
  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(NC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CIDX_W-1:0] cidx_q, cidx_d;
  logic              coeff_loaded_q, coeff_loaded_d;
  logic [15:0]       fir_coeff_in_q, fir_coeff_in_d;
  logic              fir_load_coeff_q, fir_load_coeff_d;
  logic [15:0]       fir_x0_q, fir_x0_d;
  logic [15:0]       fir_x1_q, fir_x1_d;
  logic [15:0]       fir_x2_q, fir_x2_d;
  logic              fir_start_q, fir_start_d;
  logic              y_valid_q, y_valid_d;

  logic coeff_acc;
  logic smp_acc;
  logic load_begin;

  // Handshakes: cfg_req in RUN blocks a simultaneous sample so it cannot slip in.
  assign coeff_ready = (state_q == LOAD);
  assign smp_ready   = (state_q == RUN) && !cfg_req;
  assign coeff_acc   = coeff_valid && coeff_ready;
  assign smp_acc     = smp_valid && smp_ready;
  assign load_begin  = ((state_q == IDLE) && cfg_req) || (state_q == DRAIN);

  // Control FSM: state, coefficient index and the coeff_loaded flag.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_d        = state_q;
    cidx_d         = cidx_q;
    coeff_loaded_d = coeff_loaded_q;
    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          coeff_loaded_d = 1'b0;
          cidx_d         = '0;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        // cfg_req is deliberately ignored: the datapath's own index only
        // resynchronises at 3*M or on rst, so a load must run to completion.
        if (coeff_acc) begin
          if (cidx_q == CIDX_LAST) begin
            cidx_d         = '0;
            coeff_loaded_d = 1'b1;
            state_d        = RUN;
          end else begin
            cidx_d = cidx_q + CIDX_W'(1);
          end
        end
      end
      RUN: begin
        if (cfg_req) state_d = DRAIN;
      end
      DRAIN: begin
        // One cycle lets the last fir_start retire before coefficients change.
        coeff_loaded_d = 1'b0;
        cidx_d         = '0;
        state_d        = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath pin registers: capture on accept, hold otherwise.
  always_comb begin
    fir_coeff_in_d   = coeff_acc ? coeff_data : fir_coeff_in_q;
    fir_load_coeff_d = coeff_acc;
    fir_x0_d         = smp_acc ? smp_x0 : fir_x0_q;
    fir_x1_d         = smp_acc ? smp_x1 : fir_x1_q;
    fir_x2_d         = smp_acc ? smp_x2 : fir_x2_q;
    fir_start_d      = smp_acc;
  end

`ifdef FIR3_CTRL_WARMUP_EN
  localparam int WARM_W = $clog2(M + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(M - 1);

  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              warm_ok;

  assign warm_ok = (warm_cnt_q == WARM_LAST);

  // Warm-up: count starts since the last load, saturating once M-1 earlier
  // starts have gone by; the M-th start and later ones produce y_valid.
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (load_begin) begin
      warm_cnt_d = '0;
    end else if (fir_start_q && !warm_ok) begin
      warm_cnt_d = warm_cnt_q + WARM_W'(1);
    end
    y_valid_d = fir_start_q && warm_ok;
  end

  // Warm-up counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warm_cnt_q <= '0;
    else     warm_cnt_q <= warm_cnt_d;
  end
`else
  // Every start yields a result one register later.
  always_comb begin
    y_valid_d = fir_start_q;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q          <= IDLE;
      cidx_q           <= '0;
      coeff_loaded_q   <= 1'b0;
      fir_coeff_in_q   <= '0;
      fir_load_coeff_q <= 1'b0;
      fir_x0_q         <= '0;
      fir_x1_q         <= '0;
      fir_x2_q         <= '0;
      fir_start_q      <= 1'b0;
      y_valid_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cidx_q           <= cidx_d;
      coeff_loaded_q   <= coeff_loaded_d;
      fir_coeff_in_q   <= fir_coeff_in_d;
      fir_load_coeff_q <= fir_load_coeff_d;
      fir_x0_q         <= fir_x0_d;
      fir_x1_q         <= fir_x1_d;
      fir_x2_q         <= fir_x2_d;
      fir_start_q      <= fir_start_d;
      y_valid_q        <= y_valid_d;
    end
  end

  // load_begin is only consumed by the warm-up counter.
  logic unused_load_begin;
  assign unused_load_begin = load_begin;

  assign fir_coeff_in   = fir_coeff_in_q;
  assign fir_load_coeff = fir_load_coeff_q;
  assign fir_x0         = fir_x0_q;
  assign fir_x1         = fir_x1_q;
  assign fir_x2         = fir_x2_q;
  assign fir_start      = fir_start_q;
  assign y_valid        = y_valid_q;
  assign coeff_loaded   = coeff_loaded_q;
  assign busy           = (state_q != IDLE);

endmodule
